// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operand-issue and result-consume handshakes of alu_pipe.
//   Issue side  : in_valid/in_ready, opcode, input1, input2, shiftValue
//   Result side : out_valid/out_ready, result, carry/zero/overflow/neg/illegal flags
//   master modport = issuing/consuming environment, slave modport = the ALU.
interface alu_pipe_if #(
    parameter int unsigned WIDTH   = 128,
    parameter int unsigned SHIFT_W = $clog2(WIDTH)
);
    logic               in_valid;
    logic               in_ready;
    logic [3:0]         opcode;
    logic [WIDTH-1:0]   input1;
    logic [WIDTH-1:0]   input2;
    logic [SHIFT_W-1:0] shiftValue;

    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   result;
    logic               carryFlag;
    logic               zeroFlag;
    logic               overFlowFlag;
    logic               negFlag;
    logic               illegalFlag;

    modport master (
        output in_valid, opcode, input1, input2, shiftValue, out_ready,
        input  in_ready, out_valid, result,
        input  carryFlag, zeroFlag, overFlowFlag, negFlag, illegalFlag
    );

    modport slave (
        input  in_valid, opcode, input1, input2, shiftValue, out_ready,
        output in_ready, out_valid, result,
        output carryFlag, zeroFlag, overFlowFlag, negFlag, illegalFlag
    );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready on both sides.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : alu_pipe_if.slave (operands/opcode in, result/flags out)
// S1 registers the accepted operation; S2 computes and registers result,
// flags and out_valid. in_ready is the only combinational output.
module alu_pipe #(
    parameter int unsigned WIDTH   = 128,
    parameter int unsigned SHIFT_W = $clog2(WIDTH)
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_pipe_if.slave  bus
);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_SLL = 4'd4;
    localparam logic [3:0] OP_SGT = 4'd5;
    localparam logic [3:0] OP_SLT = 4'd6;
    localparam logic [3:0] OP_SRL = 4'd7;
    localparam logic [3:0] OP_XOR = 4'd8;
    localparam logic [3:0] OP_SRA = 4'd9;

    typedef struct packed {
        logic [3:0]         opcode;
        logic [WIDTH-1:0]   a;
        logic [WIDTH-1:0]   b;
        logic [SHIFT_W-1:0] sh;
    } op_t;

    typedef struct packed {
        logic carry;
        logic zero;
        logic ovf;
        logic neg;
        logic illegal;
    } flags_t;

    op_t              s1_q, s1_d;
    logic             s1_valid_q, s1_valid_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    flags_t           flags_q, flags_d;

    logic             s1_load;
    logic             s2_load;
    logic             in_ready_c;

    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   diff_w;
    logic [WIDTH-1:0] alu_res_c;
    flags_t           alu_flags_c;

    // Handshake: S2 takes S1 when the output slot is empty or being drained.
    always_comb begin
        s2_load    = s1_valid_q && (!out_valid_q || bus.out_ready);
        in_ready_c = !s1_valid_q || s2_load;
        s1_load    = bus.in_valid && in_ready_c;
    end

    // Datapath evaluated on the S1 registers.
    always_comb begin
        sum_w       = {1'b0, s1_q.a} + {1'b0, s1_q.b};
        diff_w      = {1'b0, s1_q.a} - {1'b0, s1_q.b};
        alu_res_c   = '0;
        alu_flags_c = '0;
        case (s1_q.opcode)
            OP_ADD: begin
                alu_res_c         = sum_w[WIDTH-1:0];
                alu_flags_c.carry = sum_w[WIDTH];
                alu_flags_c.ovf   = (s1_q.a[WIDTH-1] == s1_q.b[WIDTH-1]) &&
                                    (sum_w[WIDTH-1] != s1_q.a[WIDTH-1]);
            end
            OP_SUB: begin
                // Bit WIDTH of the widened difference is the unsigned borrow.
                alu_res_c         = diff_w[WIDTH-1:0];
                alu_flags_c.carry = diff_w[WIDTH];
                alu_flags_c.ovf   = (s1_q.a[WIDTH-1] != s1_q.b[WIDTH-1]) &&
                                    (diff_w[WIDTH-1] != s1_q.a[WIDTH-1]);
            end
            OP_AND:  alu_res_c = s1_q.a & s1_q.b;
            OP_OR:   alu_res_c = s1_q.a | s1_q.b;
            OP_XOR:  alu_res_c = s1_q.a ^ s1_q.b;
            OP_SLL:  alu_res_c = s1_q.a << s1_q.sh;
            OP_SRL:  alu_res_c = s1_q.a >> s1_q.sh;
            OP_SRA:  alu_res_c = WIDTH'($signed(s1_q.a) >>> s1_q.sh);
            OP_SGT:  alu_res_c = WIDTH'($signed(s1_q.a) > $signed(s1_q.b));
            OP_SLT:  alu_res_c = WIDTH'($signed(s1_q.a) < $signed(s1_q.b));
            default: alu_flags_c.illegal = 1'b1;
        endcase
        alu_flags_c.zero = (alu_res_c == '0);
        alu_flags_c.neg  = alu_res_c[WIDTH-1];
    end

    // Next-state for both stages.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_d        = s1_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        flags_d     = flags_q;

        if (s2_load) begin
            s1_valid_d = 1'b0;
        end
        if (s1_load) begin
            s1_valid_d  = 1'b1;
            s1_d.opcode = bus.opcode;
            s1_d.a      = bus.input1;
            s1_d.b      = bus.input2;
            s1_d.sh     = bus.shiftValue;
        end

        if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
        if (s2_load) begin
            out_valid_d = 1'b1;
            result_d    = alu_res_c;
            flags_d     = alu_flags_c;
        end
    end

    // Pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_q        <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_q        <= s1_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
        end
    end

    assign bus.in_ready     = in_ready_c;
    assign bus.out_valid    = out_valid_q;
    assign bus.result       = result_q;
    assign bus.carryFlag    = flags_q.carry;
    assign bus.zeroFlag     = flags_q.zero;
    assign bus.overFlowFlag = flags_q.ovf;
    assign bus.negFlag      = flags_q.neg;
    assign bus.illegalFlag  = flags_q.illegal;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed checks on a 128-bit alu_pipe plus random streaming
// at widths 8, 32 and 128 against an arithmetic reference model.
module tb_alu_pipe;

    localparam int unsigned W  = 128;
    localparam int unsigned SW = $clog2(W);

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Directed-test instance.
    alu_pipe_if #(.WIDTH(W), .SHIFT_W(SW)) bus ();
    alu_pipe #(.WIDTH(W), .SHIFT_W(SW)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    logic [4:0] dut_f;
    assign dut_f = {bus.carryFlag, bus.zeroFlag, bus.overFlowFlag, bus.negFlag, bus.illegalFlag};

    // Streaming instances, driven through width-agnostic arrays.
    logic         s_in_valid  [3];
    logic         s_out_ready [3];
    logic [3:0]   s_op        [3];
    logic [255:0] s_a         [3];
    logic [255:0] s_b         [3];
    logic [7:0]   s_sh        [3];
    logic         s_in_ready  [3];
    logic         s_out_valid [3];
    logic [255:0] s_res       [3];
    logic [4:0]   s_flags     [3];

    for (genvar gi = 0; gi < 3; gi++) begin : g_s
        localparam int unsigned GW  = (gi == 0) ? 8 : ((gi == 1) ? 32 : 128);
        localparam int unsigned GSW = $clog2(GW);
        alu_pipe_if #(.WIDTH(GW), .SHIFT_W(GSW)) sb ();
        alu_pipe #(.WIDTH(GW), .SHIFT_W(GSW)) u_s (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (sb.slave)
        );
        assign sb.in_valid    = s_in_valid[gi];
        assign sb.out_ready   = s_out_ready[gi];
        assign sb.opcode      = s_op[gi];
        assign sb.input1      = s_a[gi][GW-1:0];
        assign sb.input2      = s_b[gi][GW-1:0];
        assign sb.shiftValue  = s_sh[gi][GSW-1:0];
        assign s_in_ready[gi]  = sb.in_ready;
        assign s_out_valid[gi] = sb.out_valid;
        assign s_res[gi]       = 256'(sb.result);
        assign s_flags[gi]     = {sb.carryFlag, sb.zeroFlag, sb.overFlowFlag, sb.negFlag, sb.illegalFlag};
    end

    typedef struct {
        logic [255:0] r;
        logic [4:0]   f;   // {carry, zero, overflow, neg, illegal}
    } exp_t;

    // Reference: operands as integers in [0, 2^w), signed views as plain numbers.
    function automatic exp_t ref_alu(input int w, input logic [3:0] op,
                                     input logic [255:0] a_in, input logic [255:0] b_in,
                                     input int sh);
        logic [256:0]        modv, mask, a, b, r;
        logic signed [258:0] sa, sb, s, hi, lo;
        logic                c, v, ill;
        exp_t                e;
        modv = 257'd1 << w;
        mask = modv - 257'd1;
        a    = {1'b0, a_in} & mask;
        b    = {1'b0, b_in} & mask;
        sa   = $signed({2'b00, a});
        sb   = $signed({2'b00, b});
        if (a[w-1]) sa = sa - $signed({2'b00, modv});
        if (b[w-1]) sb = sb - $signed({2'b00, modv});
        hi   = $signed({2'b00, modv >> 1}) - 1;
        lo   = -$signed({2'b00, modv >> 1});
        c = 1'b0; v = 1'b0; ill = 1'b0; r = '0;
        case (op)
            4'd0: begin r = (a + b) & mask; c = ((a + b) >= modv); s = sa + sb; v = (s > hi) || (s < lo); end
            4'd1: begin r = (a - b) & mask; c = (a < b);           s = sa - sb; v = (s > hi) || (s < lo); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd8: r = a ^ b;
            4'd4: r = (a << sh) & mask;
            4'd7: r = a >> sh;
            4'd9: r = 257'(sa >>> sh) & mask;
            4'd5: r = (sa > sb) ? 257'd1 : 257'd0;
            4'd6: r = (sa < sb) ? 257'd1 : 257'd0;
            default: begin r = '0; ill = 1'b1; end
        endcase
        e.r = r[255:0];
        e.f = {c, (r == '0), v, r[w-1], ill};
        return e;
    endfunction

    function automatic logic [255:0] rand_operand(input int w);
        logic [256:0] m, half;
        logic [255:0] v;
        m    = (257'd1 << w) - 257'd1;
        half = m >> 1;
        v    = {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
        case ($urandom_range(0, 5))
            0:       v = '0;
            1:       v = m[255:0];
            2:       v = m[255:0] & ~half[255:0];
            3:       v = half[255:0];
            default: v = v & m[255:0];
        endcase
        return v;
    endfunction

    // Offer one op with the output drained; report result, flags, and the
    // cycle (counted from the handshake cycle) in which out_valid is seen.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [SW-1:0] sh,
                          output logic [W-1:0] r, output logic [4:0] f, output int lat);
        int g;
        @(negedge clk);
        bus.out_ready  = 1'b1;
        bus.in_valid   = 1'b1;
        bus.opcode     = op;
        bus.input1     = a;
        bus.input2     = b;
        bus.shiftValue = sh;
        g = 0;
        #1;
        while (!bus.in_ready && g < 20) begin
            @(negedge clk);
            #1;
            g++;
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        r = bus.result;
        f = dut_f;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.opcode = '0;
        bus.input1 = '0; bus.input2 = '0; bus.shiftValue = '0;
        for (int i = 0; i < 3; i++) begin
            s_in_valid[i] = 1'b0; s_out_ready[i] = 1'b0; s_op[i] = '0;
            s_a[i] = '0; s_b[i] = '0; s_sh[i] = '0;
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", bus.out_valid); end
        n_checks++;
        if (bus.result !== '0) begin n_fail++; $display("FAIL reset_result: got %h want 0", bus.result); end
        n_checks++;
        if (dut_f !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 00000", dut_f); end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 1", bus.in_ready); end
    endtask

    task automatic test_add();
        logic [W-1:0] r; logic [4:0] f; int lat;
        run_op(4'd0, '1, W'(1), '0, r, f, lat);
        n_checks++;
        if (lat !== 2) begin n_fail++; $display("FAIL add_latency: got %0d want 2", lat); end
        n_checks++;
        if (r !== '0) begin n_fail++; $display("FAIL add_result: got %h want 0", r); end
        n_checks++;
        if (f !== 5'b11000) begin n_fail++; $display("FAIL add_flags: got %b want 11000", f); end
    endtask

    task automatic test_sub();
        logic [W-1:0] r, a, msb; logic [4:0] f; int lat;
        msb = '0; msb[W-1] = 1'b1;
        a = ~msb;
        run_op(4'd1, a, '1, '0, r, f, lat);
        n_checks++;
        if (r !== msb) begin n_fail++; $display("FAIL sub_result: got %h want %h", r, msb); end
        n_checks++;
        if (f !== 5'b10110) begin n_fail++; $display("FAIL sub_flags: got %b want 10110", f); end
    endtask

    task automatic test_cmp();
        logic [W-1:0] r, m2; logic [4:0] f; int lat;
        m2 = {W{1'b1}} - W'(1);
        run_op(4'd6, m2, W'(3), '0, r, f, lat);
        n_checks++;
        if (r !== W'(1) || f !== 5'b00000) begin n_fail++; $display("FAIL slt: got %h/%b want 1/00000", r, f); end
        run_op(4'd5, m2, W'(3), '0, r, f, lat);
        n_checks++;
        if (r !== '0 || f !== 5'b01000) begin n_fail++; $display("FAIL sgt: got %h/%b want 0/01000", r, f); end
    endtask

    task automatic test_shift_illegal();
        logic [W-1:0] r, msb; logic [4:0] f; int lat;
        msb = '0; msb[W-1] = 1'b1;
        run_op(4'd4, W'(1), '0, SW'(127), r, f, lat);
        n_checks++;
        if (r !== msb || f !== 5'b00010) begin n_fail++; $display("FAIL sll127: got %h/%b want %h/00010", r, f, msb); end
        run_op(4'd7, msb, '0, SW'(127), r, f, lat);
        n_checks++;
        if (r !== W'(1) || f !== 5'b00000) begin n_fail++; $display("FAIL srl127: got %h/%b want 1/00000", r, f); end
        run_op(4'd9, msb, '0, SW'(127), r, f, lat);
        n_checks++;
        if (r !== '1 || f !== 5'b00010) begin n_fail++; $display("FAIL sra127: got %h/%b want all-ones/00010", r, f); end
        run_op(4'd12, '1, W'(5), SW'(3), r, f, lat);
        n_checks++;
        if (r !== '0 || f !== 5'b01001) begin n_fail++; $display("FAIL illegal12: got %h/%b want 0/01001", r, f); end
    endtask

    task automatic test_backpressure();
        exp_t         q[$];
        exp_t         e;
        logic [255:0] ta, tb2;
        logic [3:0]   ops [5];
        logic [W-1:0] held_r;
        logic [4:0]   held_f;
        int           acc;
        ops[0] = 4'd0; ops[1] = 4'd1; ops[2] = 4'd8; ops[3] = 4'd3; ops[4] = 4'd2;
        @(negedge clk);
        bus.out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            ta = rand_operand(W); tb2 = rand_operand(W);
            bus.in_valid = 1'b1; bus.opcode = ops[i];
            bus.input1 = ta[W-1:0]; bus.input2 = tb2[W-1:0]; bus.shiftValue = '0;
            #1;
            if (bus.in_ready) begin acc++; q.push_back(ref_alu(W, ops[i], ta, tb2, 0)); end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        #1;
        n_checks++;
        if (acc !== 2) begin n_fail++; $display("FAIL bp_accepted: got %0d want 2", acc); end
        n_checks++;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_low: got %0b want 0", bus.in_ready); end
        held_r = bus.result; held_f = dut_f;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.result !== held_r || dut_f !== held_f || q.size() == 0 ||
            bus.result !== q[0].r[W-1:0] || dut_f !== q[0].f) begin
            n_fail++;
            $display("FAIL bp_hold: got v=%0b %h/%b", bus.out_valid, bus.result, dut_f);
        end
        // Release with both stages full and a new op offered in the same cycle.
        bus.out_ready = 1'b1;
        ta = rand_operand(W); tb2 = rand_operand(W);
        bus.in_valid = 1'b1; bus.opcode = ops[4];
        bus.input1 = ta[W-1:0]; bus.input2 = tb2[W-1:0];
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_simul_in_ready: got %0b want 1", bus.in_ready); end
        else q.push_back(ref_alu(W, ops[4], ta, tb2, 0));
        for (int k = 0; k < 3; k++) begin
            if (k == 1) bus.in_valid = 1'b0;
            n_checks++;
            if (q.size() == 0) begin
                n_fail++; $display("FAIL bp_drain%0d: reference queue empty", k);
            end else begin
                e = q.pop_front();
                if (bus.out_valid !== 1'b1 || bus.result !== e.r[W-1:0] || dut_f !== e.f) begin
                    n_fail++;
                    $display("FAIL bp_drain%0d: got v=%0b %h/%b want v=1 %h/%b",
                             k, bus.out_valid, bus.result, dut_f, e.r[W-1:0], e.f);
                end
            end
            @(negedge clk);
        end
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty_after: got %0b want 0", bus.out_valid); end
    endtask

    task automatic test_reset_midflight();
        int seen;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.opcode = 4'd0; bus.input1 = W'(7); bus.input2 = W'(9);
        @(negedge clk);
        bus.opcode = 4'd3; bus.input1 = W'(5); bus.input2 = W'(10);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_full: got rdy=%0b v=%0b want 0/1", bus.in_ready, bus.out_valid);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.result !== '0 || dut_f !== 5'b0) begin
            n_fail++; $display("FAIL rst_mid_clear: got v=%0b %h/%b want 0 0/00000", bus.out_valid, bus.result, dut_f);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_in_ready: got %0b want 1", bus.in_ready); end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        n_checks++;
        if (seen !== 0) begin n_fail++; $display("FAIL rst_mid_stale: got %0d stale results want 0", seen); end
    endtask

    task automatic test_stream(input int gi, input int w);
        exp_t         q[$];
        exp_t         e;
        logic [3:0]   op;
        logic [255:0] a, b;
        int           sh, sent, rcvd, cyc;
        sent = 0; rcvd = 0; cyc = 0;
        op = '0; a = '0; b = '0; sh = 0;
        @(negedge clk);
        while ((sent < 100 || q.size() != 0) && cyc < 3000) begin
            s_out_ready[gi] = ($urandom_range(0, 3) != 0);
            if (sent < 100 && $urandom_range(0, 4) != 0) begin
                op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
                a  = rand_operand(w);
                b  = rand_operand(w);
                sh = $urandom_range(0, w - 1);
                s_in_valid[gi] = 1'b1;
                s_op[gi] = op; s_a[gi] = a; s_b[gi] = b; s_sh[gi] = 8'(sh);
            end else begin
                s_in_valid[gi] = 1'b0;
            end
            #1;
            if (s_in_valid[gi] && s_in_ready[gi]) begin
                q.push_back(ref_alu(w, op, a, b, sh));
                sent++;
            end
            if (s_out_valid[gi] && s_out_ready[gi]) begin
                n_checks++;
                rcvd++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL stream_w%0d_extra: got unexpected result %h", w, s_res[gi]);
                end else begin
                    e = q.pop_front();
                    if (s_res[gi] !== e.r || s_flags[gi] !== e.f) begin
                        n_fail++;
                        $display("FAIL stream_w%0d_item%0d: got %h/%b want %h/%b",
                                 w, rcvd, s_res[gi], s_flags[gi], e.r, e.f);
                    end
                end
            end
            @(negedge clk);
            cyc++;
        end
        s_in_valid[gi]  = 1'b0;
        s_out_ready[gi] = 1'b0;
        n_checks++;
        if (sent !== 100 || rcvd !== 100 || q.size() != 0) begin
            n_fail++; $display("FAIL stream_w%0d_count: got sent=%0d rcvd=%0d want 100/100", w, sent, rcvd);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_add();
        test_sub();
        test_cmp();
        test_shift_illegal();
        test_backpressure();
        test_reset_midflight();
        test_stream(0, 8);
        test_stream(1, 32);
        test_stream(2, 128);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
